// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the sequential multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Quotient reported for a divide by zero.
    localparam logic [MULDIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 Booth step for MUL,
// restoring shift-subtract step (on magnitudes) for DIV.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             op,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] mq,
    input  logic             q_1,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] mq_nxt,
    output logic             q_1_nxt
);

    logic [WIDTH:0] booth_sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] div_diff;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        acc_nxt   = acc;
        mq_nxt    = mq;
        q_1_nxt   = 1'b0;
        booth_sum = acc;

        // Accumulator is one bit wider so adding/subtracting -2^(W-1) cannot overflow.
        case ({mq[0], q_1})
            2'b01:   booth_sum = acc + {opnd[WIDTH-1], opnd};
            2'b10:   booth_sum = acc - {opnd[WIDTH-1], opnd};
            default: booth_sum = acc;
        endcase

        shifted  = {acc[WIDTH-1:0], mq[WIDTH-1]};
        div_diff = shifted - {1'b0, opnd};

        if (op == OP_MUL) begin
            acc_nxt = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            mq_nxt  = {booth_sum[0], mq[WIDTH-1:1]};
            q_1_nxt = mq[0];
        end else if (shifted >= {1'b0, opnd}) begin
            acc_nxt = div_diff;
            mq_nxt  = {mq[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = shifted;
            mq_nxt  = {mq[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// Sequential signed MUL/DIV engine producing {HI,LO} with a one-cycle load strobe.
// Define MULDIV_EARLY_ZERO_EN to finish trivially-zero operations after one iteration.
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               hilo_en,
    output logic [2*WIDTH-1:0] result,
    output logic               div_by_zero
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               early_q, early_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               q_1_q, q_1_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     acc_step;
    logic [WIDTH-1:0]   mq_step;
    logic               q_1_step;
    logic [WIDTH-1:0]   quot, rem;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc     (acc_q),
        .mq      (mq_q),
        .q_1     (q_1_q),
        .opnd    (opb_q),
        .acc_nxt (acc_step),
        .mq_nxt  (mq_step),
        .q_1_nxt (q_1_step)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        early_d  = early_q;
        a_raw_d  = a_raw_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        q_1_d    = q_1_q;
        result_d = result_q;
        dbz_d    = dbz_q;

        quot = (sign_a_q ^ sign_b_q) ? -mq_step : mq_step;
        rem  = sign_a_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];

        case (state_q)
            IDLE: if (start) begin
                op_d     = op;
                sign_a_d = a[WIDTH-1];
                sign_b_d = b[WIDTH-1];
                a_raw_d  = a;
                acc_d    = '0;
                q_1_d    = 1'b0;
                cnt_d    = '0;
                result_d = '0;
                dbz_d    = 1'b0;
                state_d  = RUN;
                if (op == OP_DIV) begin
                    mq_d  = a[WIDTH-1] ? -a : a;
                    opb_d = b[WIDTH-1] ? -b : b;
                end else begin
                    mq_d  = b;
                    opb_d = a;
                end
`ifdef MULDIV_EARLY_ZERO_EN
                early_d = ((op == OP_MUL) && ((a == '0) || (b == '0))) ||
                          ((op == OP_DIV) && (a == '0) && (b != '0));
`else
                early_d = 1'b0;
`endif
            end
            RUN: begin
                acc_d = acc_step;
                mq_d  = mq_step;
                q_1_d = q_1_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (early_q) begin
                    result_d = '0;
                    dbz_d    = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    if (op_q == OP_MUL) begin
                        result_d = {acc_step[WIDTH-1:0], mq_step};
                    end else if (opb_q == '0) begin
                        result_d = {a_raw_q, WIDTH'(signed'(DIV0_QUOTIENT))};
                        dbz_d    = 1'b1;
                    end else begin
                        result_d = {rem, quot};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State updates on the falling edge to line up with the datapath registers.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            early_q  <= 1'b0;
            a_raw_q  <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            q_1_q    <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            early_q  <= early_d;
            a_raw_q  <= a_raw_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            q_1_q    <= q_1_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign hilo_en     = done;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed + small random bench for muldiv_seq_unit with a result scoreboard.
// Outputs are sampled on the rising edge, half a cycle away from the active falling edge.
module tb_muldiv_seq_unit;

    typedef struct packed {
        logic [63:0] res;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hilo_en;
    logic [63:0] result;
    logic        div_by_zero;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb_q[$];

`ifdef MULDIV_EARLY_ZERO_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 32;
`endif

    muldiv_seq_unit dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hilo_en     (hilo_en),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
        exp_t   e;
        longint p;
        int     q;
        int     r;
        e.dbz = 1'b0;
        if (o == 1'b0) begin
            p     = longint'($signed(x)) * longint'($signed(y));
            e.res = p;
        end else if (y == 32'd0) begin
            e.res = {x, 32'hFFFF_FFFF};
            e.dbz = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.res = {32'h0, 32'h8000_0000};
        end else begin
            q     = $signed(x) / $signed(y);
            r     = $signed(x) % $signed(y);
            e.res = {r, q};
        end
        return e;
    endfunction

    // Pulse start for one cycle and record what the result must be.
    task automatic launch(input logic o, input logic [31:0] x, input logic [31:0] y, input exp_t e);
        @(posedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        sb_q.push_back(e);
        @(posedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done, then compare against the scoreboard head.
    task automatic finish(input string tag, input int lat0, input int exp_lat);
        int   lat;
        exp_t e;
        lat = lat0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = '0;
        check({tag, "_result"}, result, e.res);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        check({tag, "_hilo_en"}, 64'(hilo_en), 64'(1));
        check({tag, "_busy_in_done"}, 64'(busy), 64'(1));
        @(posedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'(0));
        check({tag, "_busy_fall"}, 64'(busy), 64'(0));
    endtask

    initial begin
        bit seen_done;

        clr   = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state, with a start request overridden by clr.
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo_en", 64'(hilo_en), 64'(0));
        check("rst_result", result, 64'h0);
        check("rst_dbz", 64'(div_by_zero), 64'(0));
        start = 1'b0;
        clr   = 1'b0;

        launch(1'b0, 32'd7, 32'hFFFF_FFFD, '{64'hFFFF_FFFF_FFFF_FFEB, 1'b0});
        finish("mul_7_m3", 0, 32);

        launch(1'b0, 32'h8000_0000, 32'h8000_0000, '{64'h4000_0000_0000_0000, 1'b0});
        finish("mul_min_min", 0, 32);

        launch(1'b1, 32'hFFFF_FFF9, 32'd2, '{64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
        finish("div_m7_2", 0, 32);

        launch(1'b1, 32'd7, 32'hFFFF_FFFE, '{64'h0000_0001_FFFF_FFFD, 1'b0});
        finish("div_7_m2", 0, 32);

        launch(1'b1, 32'd5, 32'd0, '{64'h0000_0005_FFFF_FFFF, 1'b1});
        finish("div_by_zero", 0, 32);

        launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, '{64'h0000_0000_8000_0000, 1'b0});
        finish("div_overflow", 0, 32);

        // Second start while busy and operand changes must not disturb the run.
        launch(1'b1, 32'd100, 32'd7, '{64'h0000_0002_0000_000E, 1'b0});
        repeat (3) @(posedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd999;
        b     = 32'd3;
        @(posedge clk);
        start = 1'b0;
        finish("div_ignore_start", 4, 32);

        // Abort a MUL mid-run with clr.
        launch(1'b0, 32'd1234, 32'd5678, '{64'd0, 1'b0});
        repeat (9) @(posedge clk);
        clr = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_result", result, 64'h0);
        check("abort_done", 64'(done), 64'(0));
        void'(sb_q.pop_front());
        @(posedge clk);
        clr = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            if (done === 1'b1 || hilo_en === 1'b1) seen_done = 1'b1;
        end
        check("abort_no_pulse", 64'(seen_done), 64'(0));

        launch(1'b0, 32'hFFFF_FFFB, 32'd6, '{64'hFFFF_FFFF_FFFF_FFE2, 1'b0});
        finish("mul_after_abort", 0, 32);

        launch(1'b0, 32'd0, 32'd123, '{64'h0, 1'b0});
        finish("mul_zero", 0, ZERO_LAT);

        for (int i = 0; i < 6; i++) begin
            logic        o;
            logic [31:0] x;
            logic [31:0] y;
            o = i[0];
            x = $urandom;
            y = (i == 3) ? 32'($urandom_range(1, 20)) : $urandom;
            if (y == 32'd0) y = 32'd3;
            launch(o, x, y, model(o, x, y));
            finish("random", 0, 32);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
